// File: rtl/udc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udc_pkg
//  Description : Shared constants, mode encodings and parameter legality
//                helper for the parametrised up/down counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package udc_pkg;

    localparam int WIDTH_MAX = 32;

    localparam logic WRAP     = 1'b0;
    localparam logic SATURATE = 1'b1;

    // Returns MAX_VAL limited to the largest value WIDTH bits can hold;
    // a result different from max_val means the parameter pair is illegal.
    function automatic longint unsigned clamp_max(input int width,
                                                  input longint unsigned max_val);
        longint unsigned lim;
        lim = (64'd1 << width) - 64'd1;
        return (max_val > lim) ? lim : max_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udc_next_val.sv
`default_nettype none
// ============================================================================
//  Module      : udc_next_val
//  Description : Combinational next-count calculation for one count step,
//                with wrap/saturate handling at 0 and MAX_VAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module udc_next_val
    import udc_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic             sat,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt
);

    // One extra bit keeps MAX_VAL = 2**WIDTH-1 compare and increment exact.
    localparam logic [WIDTH:0] c_max = MAX_VAL[WIDTH:0];

    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_step;

    always_comb begin
        w_cnt_ext  = {1'b0, count};
        w_step     = w_cnt_ext;
        next_count = count;
        wrap_evt   = 1'b0;
        if (up_down) begin
            if (w_cnt_ext < c_max) begin
                w_step     = w_cnt_ext + 1'b1;
                next_count = w_step[WIDTH-1:0];
            end else if (sat == WRAP) begin
                next_count = '0;
                wrap_evt   = 1'b1;
            end
        end else begin
            if (w_cnt_ext != '0) begin
                w_step     = w_cnt_ext - 1'b1;
                next_count = w_step[WIDTH-1:0];
            end else if (sat == WRAP) begin
                next_count = c_max[WIDTH-1:0];
                wrap_evt   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param
//  Description : Parametrised up/down counter with load, enable, per-cycle
//                wrap/saturate mode and terminal-count flags. Optional sticky
//                overflow/underflow flags via UDC_STICKY_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param
    import udc_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
`ifdef UDC_STICKY_FLAGS_EN
    ,
    input  logic             clr_flags,
    output logic             ovf,
    output logic             unf
`endif
);

    localparam logic [WIDTH:0] c_max = MAX_VAL[WIDTH:0];

    if (WIDTH < 2 || WIDTH > WIDTH_MAX || MAX_VAL < 64'd1 ||
        clamp_max(WIDTH, MAX_VAL) != MAX_VAL) begin : g_param_check
        $error("updown_counter_param: illegal WIDTH/MAX_VAL combination");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_count;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_load_clamped;

    udc_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_val (
        .count      (r_count),
        .up_down    (up_down),
        .sat        (sat),
        .next_count (w_next_count),
        .wrap_evt   (w_wrap_evt)
    );

    assign w_load_clamped = ({1'b0, load_val} > c_max) ? c_max[WIDTH-1:0] : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_count <= w_next_count;
            r_wrap  <= w_wrap_evt;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count  = r_count;
    assign wrap   = r_wrap;
    assign at_max = (r_count == c_max[WIDTH-1:0]);
    assign at_min = (r_count == '0);

`ifdef UDC_STICKY_FLAGS_EN
    logic r_ovf;
    logic r_unf;
    logic w_up_limit;
    logic w_dn_limit;

    // Limit events cover both the wrap and the saturate-hold cases.
    assign w_up_limit = en && !load &&  up_down && at_max;
    assign w_dn_limit = en && !load && !up_down && at_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_up_limit)     r_ovf <= 1'b1;
            else if (clr_flags) r_ovf <= 1'b0;
            if (w_dn_limit)     r_unf <= 1'b1;
            else if (clr_flags) r_unf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`endif

endmodule
`default_nettype wire
